// File: rtl/fft_out_stream_pkg.sv
// Shared FFT sizing defaults, streamer state encoding and the bit-reverse helper
// used by both the butterfly engine and the output loader.
package fft_out_stream_pkg;

  localparam int DEF_D_WIDTH     = 64;
  localparam int DEF_LOG_2_WIDTH = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_e;

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_stream_frame_buffer.sv
// Frame buffer: D_WIDTH x 32-bit register file, loaded in parallel from the
// engine's outputs and read through one indexed port.
module fft_frame_buffer
  import fft_out_stream_pkg::*;
#(
  parameter int D_WIDTH     = DEF_D_WIDTH,
  parameter int LOG_2_WIDTH = DEF_LOG_2_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_i,
  input  logic [D_WIDTH-1:0][15:0]       wr_re_i,
  input  logic [D_WIDTH-1:0][15:0]       wr_im_i,
  input  logic [LOG_2_WIDTH-1:0]         rd_addr_i,
  output logic [15:0]                    rd_re_o,
  output logic [15:0]                    rd_im_o
);

  logic [D_WIDTH-1:0][31:0] mem_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (load_i) begin
      for (int i = 0; i < D_WIDTH; i++) begin
        mem_q[i] <= {wr_re_i[i], wr_im_i[i]};
      end
    end
  end

  assign rd_re_o = mem_q[rd_addr_i][31:16];
  assign rd_im_o = mem_q[rd_addr_i][15:0];

endmodule

// File: rtl/fft_out_stream.sv
// Streams a completed FFT frame one complex sample per accepted beat, in natural
// frequency order (bit-reversed buffer order) or raw buffer order.
module fft_out_stream
  import fft_out_stream_pkg::*;
#(
  parameter int D_WIDTH     = DEF_D_WIDTH,
  parameter int LOG_2_WIDTH = DEF_LOG_2_WIDTH,
  parameter int BITREV      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       capture,
  input  logic [D_WIDTH-1:0][15:0]   in_re,
  input  logic [D_WIDTH-1:0][15:0]   in_im,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_re,
  output logic [15:0]                out_im,
  output logic [LOG_2_WIDTH-1:0]     out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       drop_err
);

  localparam logic [LOG_2_WIDTH-1:0] K_LAST = LOG_2_WIDTH'(D_WIDTH - 1);

  stream_state_e              state_q;
  logic [LOG_2_WIDTH-1:0]     k_q;
  logic [LOG_2_WIDTH-1:0]     k_d;
  logic                       valid_q;
  logic                       last_q;
  logic                       drop_q;
  logic                       accept;
  logic                       at_last;
  logic                       load;
  logic [LOG_2_WIDTH-1:0]     rd_addr;
  logic [31:0]                k_rev;

  assign k_d     = k_q + 1'b1;
  assign accept  = valid_q & out_ready;
  assign at_last = (k_q == K_LAST);
  // A capture is only honoured when the buffer is free: idle, or the final beat leaves this edge.
  assign load    = capture & ((state_q == IDLE) | (accept & at_last));

  assign k_rev = bitrev({{(32-LOG_2_WIDTH){1'b0}}, k_q}, LOG_2_WIDTH);

  generate
    if (BITREV != 0) begin : g_rev
      assign rd_addr = k_rev[LOG_2_WIDTH-1:0];
    end else begin : g_lin
      assign rd_addr = k_q;
    end
  endgenerate

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q <= STREAM;
            k_q     <= '0;
            valid_q <= 1'b1;
            last_q  <= (K_LAST == '0);
          end
        end
        STREAM: begin
          if (accept) begin
            if (at_last) begin
              if (capture) begin
                k_q    <= '0;
                last_q <= (K_LAST == '0);
              end else begin
                state_q <= IDLE;
                k_q     <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end
            end else begin
              k_q    <= k_d;
              last_q <= (k_d == K_LAST);
            end
          end
          if (capture && !(accept && at_last)) drop_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  fft_frame_buffer #(
    .D_WIDTH     (D_WIDTH),
    .LOG_2_WIDTH (LOG_2_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .wr_re_i   (in_re),
    .wr_im_i   (in_im),
    .rd_addr_i (rd_addr),
    .rd_re_o   (out_re),
    .rd_im_o   (out_im)
  );

  assign out_valid = valid_q;
  assign busy      = valid_q;
  assign out_last  = last_q;
  assign out_index = k_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_fft_out_stream.sv
// Directed bench for fft_out_stream: a bit-reversed and a buffer-order instance
// share clock, reset and input frame; state changes on falling edges.
module tb_fft_out_stream;

  logic               clk;
  logic               rst;
  logic               capture;
  logic [63:0][15:0]  in_re;
  logic [63:0][15:0]  in_im;
  logic               out_ready;

  logic               r_valid, r_last, r_busy, r_drop;
  logic [15:0]        r_re, r_im;
  logic [5:0]         r_index;
  logic               n_valid, n_last, n_busy, n_drop;
  logic [15:0]        n_re, n_im;
  logic [5:0]         n_index;

  int passed;
  int total;

  fft_out_stream #(.D_WIDTH(64), .LOG_2_WIDTH(6), .BITREV(1)) dut_r (
    .clk(clk), .rst(rst), .capture(capture), .in_re(in_re), .in_im(in_im),
    .out_valid(r_valid), .out_ready(out_ready), .out_re(r_re), .out_im(r_im),
    .out_index(r_index), .out_last(r_last), .busy(r_busy), .drop_err(r_drop)
  );

  fft_out_stream #(.D_WIDTH(64), .LOG_2_WIDTH(6), .BITREV(0)) dut_n (
    .clk(clk), .rst(rst), .capture(capture), .in_re(in_re), .in_im(in_im),
    .out_valid(n_valid), .out_ready(out_ready), .out_re(n_re), .out_im(n_im),
    .out_index(n_index), .out_last(n_last), .busy(n_busy), .drop_err(n_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rev6(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (((k >> b) & 1) != 0) r = r | (1 << (5 - b));
    return r;
  endfunction

  // Expected {valid, index, re, im, last} for beat k of a frame whose element i is (rb+i, ib+i).
  function automatic logic [39:0] exp_beat(input int k, input int rb, input int ib, input bit rev);
    int p;
    p = rev ? rev6(k) : k;
    return {1'b1, 6'(k), 16'(rb + p), 16'(ib + p), (k == 63)};
  endfunction

  task automatic set_frame(input int rb, input int ib);
    for (int i = 0; i < 64; i++) begin
      in_re[i] = 16'(rb + i);
      in_im[i] = 16'(ib + i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    capture = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic start_frame();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] got;
    rst = 1'b0;
    capture = 1'b0;
    out_ready = 1'b1;
    set_frame(0, 100);
    #1;
    got = {r_valid, r_busy, r_last, r_drop, r_index, r_re, r_im, 2'b00};
    total++;
    if (got !== 40'h0) $display("FAIL reset_state got %h want %h", got, 40'h0);
    else passed++;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({r_valid, r_busy, n_valid} !== 3'b000)
      $display("FAIL idle_after_reset got %b want 000", {r_valid, r_busy, n_valid});
    else passed++;
  endtask

  task automatic test_stream();
    logic [39:0] got;
    int errs;
    do_reset();
    set_frame(0, 100);
    out_ready = 1'b1;
    start_frame();
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 1) begin
        total++;
        if ({r_re, r_im} !== {16'd32, 16'd132})
          $display("FAIL stream_k1 got re=%0d im=%0d want re=32 im=132", r_re, r_im);
        else passed++;
      end
      got = {r_valid, r_index, r_re, r_im, r_last};
      total++;
      if (got !== exp_beat(k, 0, 100, 1'b1)) begin
        $display("FAIL stream_beat k=%0d got %h want %h", k, got, exp_beat(k, 0, 100, 1'b1));
        errs++;
      end else passed++;
      if (errs > 4) break;
      tick();
    end
    total++;
    if ({r_valid, r_busy, r_last} !== 3'b000)
      $display("FAIL stream_end got %b want 000", {r_valid, r_busy, r_last});
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [39:0] got;
    logic [3:0]  pat;
    logic        r;
    int k, lasts, cyc, errs;
    do_reset();
    set_frame(0, 100);
    out_ready = 1'b1;
    start_frame();
    pat = 4'b1001;
    k = 0; lasts = 0; cyc = 0; errs = 0;
    while (k < 64 && cyc < 400) begin
      got = {r_valid, r_index, r_re, r_im, r_last};
      total++;
      if (got !== exp_beat(k, 0, 100, 1'b1)) begin
        $display("FAIL bp_beat k=%0d cyc=%0d got %h want %h", k, cyc, got, exp_beat(k, 0, 100, 1'b1));
        errs++;
      end else passed++;
      if (errs > 4) break;
      r = pat[3 - (cyc % 4)];
      out_ready = r;
      tick();
      if (r) begin
        if (k == 63) lasts++;
        k++;
      end
      cyc++;
    end
    total++;
    if (k != 64 || lasts != 1 || r_valid !== 1'b0)
      $display("FAIL bp_count got beats=%0d lasts=%0d valid=%b want 64 1 0", k, lasts, r_valid);
    else passed++;
  endtask

  task automatic test_drop();
    logic [39:0] got;
    int errs;
    do_reset();
    set_frame(0, 100);
    out_ready = 1'b1;
    start_frame();
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      got = {r_valid, r_index, r_re, r_im, r_last};
      total++;
      if (got !== exp_beat(k, 0, 100, 1'b1)) begin
        $display("FAIL drop_beat k=%0d got %h want %h", k, got, exp_beat(k, 0, 100, 1'b1));
        errs++;
      end else passed++;
      if (errs > 4) break;
      if (k == 11) begin
        total++;
        if (r_drop !== 1'b1) $display("FAIL drop_set got %b want 1", r_drop);
        else passed++;
      end
      if (k == 10) begin
        set_frame(900, 950);
        capture = 1'b1;
      end else begin
        capture = 1'b0;
      end
      tick();
    end
    capture = 1'b0;
    tick();
    tick();
    total++;
    if ({r_drop, r_valid} !== 2'b10) $display("FAIL drop_sticky got %b want 10", {r_drop, r_valid});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [39:0] got;
    int drops;
    do_reset();
    set_frame(0, 100);
    out_ready = 1'b1;
    start_frame();
    drops = 0;
    for (int k = 0; k < 64; k++) begin
      if (r_valid !== 1'b1) drops++;
      if (k == 63) begin
        set_frame(500, 600);
        capture = 1'b1;
      end
      tick();
    end
    capture = 1'b0;
    got = {r_valid, r_index, r_re, r_im, r_last};
    total++;
    if (got !== exp_beat(0, 500, 600, 1'b1))
      $display("FAIL b2b_k0 got %h want %h", got, exp_beat(0, 500, 600, 1'b1));
    else passed++;
    tick();
    got = {r_valid, r_index, r_re, r_im, r_last};
    total++;
    if (got !== exp_beat(1, 500, 600, 1'b1))
      $display("FAIL b2b_k1 got %h want %h", got, exp_beat(1, 500, 600, 1'b1));
    else passed++;
    total++;
    if (drops != 0 || r_drop !== 1'b0)
      $display("FAIL b2b_flags got drops=%0d drop_err=%b want 0 0", drops, r_drop);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int seen;
    do_reset();
    set_frame(0, 100);
    out_ready = 1'b1;
    start_frame();
    for (int k = 0; k < 20; k++) tick();
    total++;
    if (r_index !== 6'd20) $display("FAIL mid_index got %0d want 20", r_index);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if ({r_valid, r_busy, r_last, r_index, r_re} !== 25'h0)
      $display("FAIL mid_reset got v=%b b=%b idx=%0d re=%0d want 0 0 0 0", r_valid, r_busy, r_index, r_re);
    else passed++;
    tick();
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (r_valid !== 1'b0 || r_busy !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL mid_release got %0d valid cycles want 0", seen);
    else passed++;
  endtask

  task automatic test_nobitrev();
    logic [39:0] got;
    int errs;
    do_reset();
    set_frame(0, 100);
    out_ready = 1'b1;
    start_frame();
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      got = {n_valid, n_index, n_re, n_im, n_last};
      total++;
      if (got !== exp_beat(k, 0, 100, 1'b0)) begin
        $display("FAIL linear_beat k=%0d got %h want %h", k, got, exp_beat(k, 0, 100, 1'b0));
        errs++;
      end else passed++;
      if (errs > 4) break;
      tick();
    end
    total++;
    if (n_valid !== 1'b0) $display("FAIL linear_end got %b want 0", n_valid);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b0;
    capture = 1'b0;
    out_ready = 1'b0;
    in_re = '0;
    in_im = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_nobitrev();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
